// File: rtl/gate_seq_ctrl.sv
// Exhaustive 32-vector sequencer for the five-input gate_construct datapath.
// Optional on-chip comparison against an expected truth table: GATE_SEQ_COMPARE_EN.
module gate_seq_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_v,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic        o_d,
  output logic        o_e,
  output logic        o_busy,
  output logic        o_done,
  output logic [4:0]  o_idx,
  output logic [31:0] o_table,
`ifdef GATE_SEQ_COMPARE_EN
  input  logic [31:0] i_expect,
  output logic        o_pass,
  output logic [5:0]  o_err_cnt,
  output logic [4:0]  o_first_err,
`endif
  output logic [1:0]  o_state
);

  // Handshake: i_start is a request sampled only in IDLE (i_abort wins);
  // o_busy high means a run owns the datapath; o_done pulses once when
  // o_table holds a complete capture. i_abort ends a busy run at the next edge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  // The vector index itself is the registered stimulus.
  assign {o_e, o_d, o_c, o_b, o_a} = o_idx;
  assign o_state = state;

`ifdef GATE_SEQ_COMPARE_EN
  logic       mismatch;
  logic [5:0] err_next;

  always_comb begin
    mismatch = (i_v != i_expect[o_idx]);
    err_next = o_err_cnt;
    if (mismatch && (o_err_cnt != 6'd32)) err_next = o_err_cnt + 6'd1;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      o_idx       <= '0;
      o_table     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
`ifdef GATE_SEQ_COMPARE_EN
      o_pass      <= 1'b0;
      o_err_cnt   <= '0;
      o_first_err <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !i_abort) begin
            o_table    <= '0;
            o_idx      <= '0;
            settle_cnt <= '0;
            o_busy     <= 1'b1;
            state      <= SETTLE;
`ifdef GATE_SEQ_COMPARE_EN
            o_pass      <= 1'b0;
            o_err_cnt   <= '0;
            o_first_err <= '0;
`endif
          end
        end
        SETTLE: begin
          if (i_abort) begin
            o_idx  <= '0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
          end
        end
        SAMPLE: begin
          // An abort here drops the in-flight vector without writing it.
          if (i_abort) begin
            o_idx  <= '0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            o_table[o_idx] <= i_v;
`ifdef GATE_SEQ_COMPARE_EN
            o_err_cnt <= err_next;
            if (mismatch && (o_err_cnt == 6'd0)) o_first_err <= o_idx;
`endif
            if (o_idx == 5'd31) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= DONE;
`ifdef GATE_SEQ_COMPARE_EN
              o_pass <= (err_next == 6'd0);
`endif
            end else begin
              o_idx      <= o_idx + 5'd1;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: a truth-table datapath model, randomized functions,
// and a queue of expected captures checked whenever o_done pulses.
module tb_gate_seq_ctrl;

  localparam int SETTLE_CYC = 2;
  localparam int HOLD       = SETTLE_CYC + 1;
  localparam int RUN_CYC    = 32 * HOLD;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_v;
  logic        o_a, o_b, o_c, o_d, o_e;
  logic        o_busy, o_done;
  logic [4:0]  o_idx;
  logic [31:0] o_table;
  logic [1:0]  o_state;
`ifdef GATE_SEQ_COMPARE_EN
  logic [31:0] i_expect = '0;
  logic        o_pass;
  logic [5:0]  o_err_cnt;
  logic [4:0]  o_first_err;
`endif

  // Datapath model: func is the gate function's truth table.
  logic [31:0] func = '0;
  assign i_v = func[{o_e, o_d, o_c, o_b, o_a}];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int done_gap = 0;
  logic [31:0] exp_q[$];

  gate_seq_ctrl #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_v(i_v), .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_d(o_d), .o_e(o_e),
    .o_busy(o_busy), .o_done(o_done), .o_idx(o_idx), .o_table(o_table),
`ifdef GATE_SEQ_COMPARE_EN
    .i_expect(i_expect), .o_pass(o_pass), .o_err_cnt(o_err_cnt),
    .o_first_err(o_first_err),
`endif
    .o_state(o_state)
  );

  // clock / reset timing
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: truth table of AND (0), XOR (1) or OR (2) over five inputs
  function automatic logic [31:0] table_of(input int kind);
    logic [31:0] t;
    logic [4:0]  b;
    t = '0;
    for (int k = 0; k < 32; k++) begin
      b = 5'(k);
      case (kind)
        0:       t[k] = &b;
        1:       t[k] = ^b;
        default: t[k] = |b;
      endcase
    end
    return t;
  endfunction

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (i_rst_n && o_done) begin
      done_cnt++;
      if (last_done_cyc >= 0) done_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
      check("done_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("table_at_done", o_table, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Entered at the negedge right after the start edge E0.
  task automatic watch_run(input bit chk_hold);
    int cycles = 0;
    int run_len = 0;
    int cur = 0;
    int errs = 0;
    logic [4:0] v;
    while (!o_done && cycles < RUN_CYC + 20) begin
      v = {o_e, o_d, o_c, o_b, o_a};
      if (v == 5'(cur) && o_idx == 5'(cur) && run_len < HOLD) run_len++;
      else if (v == 5'(cur + 1) && o_idx == v && run_len == HOLD) begin
        cur++;
        run_len = 1;
      end else errs++;
      if (!o_busy) errs++;
      @(negedge i_clk);
      cycles++;
    end
    check("run_latency", cycles, RUN_CYC);
    check("busy_low_at_done", o_busy, 0);
    if (chk_hold) begin
      check("hold_errs", errs, 0);
      check("last_idx", cur, 31);
      check("last_hold", run_len, HOLD);
    end
    @(negedge i_clk);
    check("done_one_cycle", o_done, 0);
  endtask

  task automatic wait_idx(input logic [4:0] n);
    int t = 0;
    while (o_idx != n && t < RUN_CYC) begin
      @(negedge i_clk);
      t++;
    end
    check("reach_idx", o_idx, n);
  endtask

  task automatic full_run(input logic [31:0] f, input bit chk_hold);
    func = f;
    exp_q.push_back(f);
    pulse_start();
    watch_run(chk_hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int exp_runs;
    int t;
    logic [31:0] f;

    repeat (3) @(negedge i_clk);
    check("rst_table", o_table, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_idx", o_idx, 0);
    check("rst_vec", {o_e, o_d, o_c, o_b, o_a}, 0);
    check("rst_state", o_state, 0);
`ifdef GATE_SEQ_COMPARE_EN
    check("rst_pass", o_pass, 0);
    check("rst_err_cnt", o_err_cnt, 0);
    check("rst_first_err", o_first_err, 0);
`endif
    i_rst_n = 1'b1;
    @(negedge i_clk);

    full_run(table_of(0), 1);
    check("and_table", o_table, 32'h8000_0000);
    full_run(table_of(1), 1);
    check("xor_table", o_table, 32'h9669_6996);

    // start and abort together in IDLE: start dropped, table untouched
    f = func;
    @(negedge i_clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    check("idle_abort_busy", o_busy, 0);
    check("idle_abort_table", o_table, f);

    repeat (3) full_run($urandom, 0);

    // abort at index 10
    func = $urandom;
    d0 = done_cnt;
    pulse_start();
    wait_idx(5'd10);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_vec", {o_e, o_d, o_c, o_b, o_a}, 0);
    check("abort_idx", o_idx, 0);
    check("abort_table", o_table, func & 32'h0000_03FF);
    repeat (6) @(negedge i_clk);
    check("abort_no_done", done_cnt - d0, 0);
    full_run($urandom, 0);

    // reset at index 17
    func = $urandom | 32'h0000_0001;
    pulse_start();
    wait_idx(5'd17);
    i_rst_n = 1'b0;
    #1;
    check("midrst_table", o_table, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_idx", o_idx, 0);
    check("midrst_vec", {o_e, o_d, o_c, o_b, o_a}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    full_run($urandom, 1);

`ifdef GATE_SEQ_COMPARE_EN
    begin
      int exp_first;
      i_expect = 32'h8000_0000;
      full_run(table_of(2), 0);
      exp_first = 0;
      for (int k = 31; k >= 0; k--) if (func[k] != i_expect[k]) exp_first = k;
      check("cmp_err_cnt", o_err_cnt, $countones(func ^ i_expect));
      check("cmp_first_err", o_first_err, exp_first);
      check("cmp_pass", o_pass, 0);
      i_expect = 32'hFFFF_FFFE;
      full_run(table_of(2), 0);
      check("cmp2_err_cnt", o_err_cnt, $countones(func ^ i_expect));
      check("cmp2_first_err", o_first_err, 0);
      check("cmp2_pass", o_pass, 1);
    end
`endif

    // start held for 200 edges, with a one-cycle dip and a later pulse mid-run
    func = $urandom;
    exp_runs = (199 / (RUN_CYC + 2)) + 1;
    for (int r = 0; r < exp_runs; r++) exp_q.push_back(func);
    d0 = done_cnt;
    @(negedge i_clk);
    i_start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      if (c == 50) i_start = 1'b0;
      else if (c == 51) i_start = 1'b1;
    end
    i_start = 1'b0;
    repeat (30) @(negedge i_clk);
    pulse_start();
    t = 0;
    while (o_busy && t < RUN_CYC + 10) begin
      @(negedge i_clk);
      t++;
    end
    check("held_run_ends", o_busy, 0);
    repeat (5) @(negedge i_clk);
    check("held_done_count", done_cnt - d0, exp_runs);
    check("held_done_gap", done_gap, RUN_CYC + 2);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
